// File: rtl/mult_n_1_arb_if.sv
// Handshake bundle for mult_n_1_arb: N flattened producer channels in, one registered word out.
// The slave modport is the arbiter side; the master modport is the producer/consumer side.
interface mult_n_1_arb_if #(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  N     = 4,
    localparam int unsigned SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_src,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_src,
        output out_valid
    );
endinterface

// File: rtl/mult_n_1_arb.sv
// Registered N:1 selector with valid/ready handshakes, fixed-select or round-robin per cycle.
// Define MULT_N_1_ARB_CNT_EN to add xfer_cnt_o, a saturating count of output transfers.
module mult_n_1_arb #(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mode_i,
    input  logic [SELW-1:0] sel_i,
    mult_n_1_arb_if.slave   bus
`ifdef MULT_N_1_ARB_CNT_EN
    ,
    output logic [15:0]     xfer_cnt_o
`endif
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             can_accept, in_xfer, out_xfer;
    logic             grant_vld, rr_found;
    logic [SELW-1:0]  grant_idx, rr_idx, rr_cand;
    logic [N-1:0]     in_ready;
    logic [WIDTH-1:0] grant_data;
    int unsigned      cand;

    assign can_accept = !out_valid_q || bus.out_ready;
    assign out_xfer   = out_valid_q && bus.out_ready;

    // First valid channel at or after ptr_q, wrapping past N-1 back to 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        cand     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            rr_cand = SELW'(cand);
            if (!rr_found && bus.in_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        if (mode_i) begin
            grant_vld = rr_found;
            grant_idx = rr_idx;
        end else begin
            grant_vld = (32'(sel_i) < N);
            grant_idx = sel_i;
        end
    end

    // Fixed mode raises ready on the selected channel regardless of its valid.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant_idx) == i) begin
                grant_data  = bus.in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !rst_i && can_accept && grant_vld && (!mode_i || bus.in_valid[i]);
            end
        end
    end

    assign in_xfer = |(in_ready & bus.in_valid);

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (in_xfer) begin
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode_i) begin
                ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

`ifdef MULT_N_1_ARB_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign xfer_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_mult_n_1_arb.sv
// Randomised and directed bench for mult_n_1_arb (N=4 main, N=2 legacy, N=3 out-of-range select).
// The N=4 instance is tracked every cycle by a transaction-level model of the arbiter.
module tb_mult_n_1_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       mode4, mode2, mode3;
    logic [1:0] sel4, sel3;
    logic [0:0] sel2;
`ifdef MULT_N_1_ARB_CNT_EN
    logic [15:0] cnt4, cnt2, cnt3;
`endif

    mult_n_1_arb_if #(.WIDTH(16), .N(4)) bus4 ();
    mult_n_1_arb_if #(.WIDTH(16), .N(2)) bus2 ();
    mult_n_1_arb_if #(.WIDTH(16), .N(3)) bus3 ();

    mult_n_1_arb #(.WIDTH(16), .N(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode4), .sel_i(sel4), .bus(bus4)
`ifdef MULT_N_1_ARB_CNT_EN
        , .xfer_cnt_o(cnt4)
`endif
    );
    mult_n_1_arb #(.WIDTH(16), .N(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode2), .sel_i(sel2), .bus(bus2)
`ifdef MULT_N_1_ARB_CNT_EN
        , .xfer_cnt_o(cnt2)
`endif
    );
    mult_n_1_arb #(.WIDTH(16), .N(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode3), .sel_i(sel3), .bus(bus3)
`ifdef MULT_N_1_ARB_CNT_EN
        , .xfer_cnt_o(cnt3)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model of the N=4 instance.
    logic        m_valid = 1'b0;
    logic [15:0] m_data = '0;
    logic [1:0]  m_src = '0;
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic [3:0]  e_ready;
    int          e_g;

    function automatic int ref_grant(logic md, logic [1:0] s, logic [3:0] v, int p);
        if (!md) return (int'(s) < 4) ? int'(s) : -1;
        for (int k = 0; k < 4; k++) begin
            int c = (p + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Mid-cycle: derive the expected grant and ready vector from the current inputs.
    task automatic prep();
        @(negedge clk);
        e_g = ref_grant(mode4, sel4, bus4.in_valid, m_ptr);
        e_ready = '0;
        if (!rst && (!m_valid || bus4.out_ready) && e_g >= 0 && (!mode4 || bus4.in_valid[e_g]))
            e_ready[e_g] = 1'b1;
    endtask

    // Clock edge: apply the transfer rules to the model, then settle.
    task automatic adv();
        logic xin, xout;
        logic [15:0] d;
        xin  = |(bus4.in_valid & e_ready);
        xout = m_valid && bus4.out_ready;
        d = '0;
        if (e_g >= 0) d = bus4.in_data[e_g*16 +: 16];
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (xout && m_cnt < 65535) m_cnt++;
            if (xin) begin
                m_valid = 1'b1;
                m_data  = d;
                m_src   = 2'(e_g);
                if (mode4) m_ptr = (e_g + 1) % 4;
            end else if (xout) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mode4 = 1'($urandom); sel4 = 2'($urandom);
            bus4.in_valid = 4'hF; bus4.in_data = {$urandom(), $urandom()}; bus4.out_ready = 1'b1;
            prep();
            checks++;
            if (bus4.in_ready !== 4'b0000) begin
                failures++; $display("FAIL reset_ready got=%b exp=0000", bus4.in_ready);
            end
            adv();
            checks++;
            if ({bus4.out_valid, bus4.out_src, bus4.out_data} !== 19'd0) begin
                failures++;
                $display("FAIL reset_out got v=%b src=%0d data=%h exp all zero",
                         bus4.out_valid, bus4.out_src, bus4.out_data);
            end
        end
        bus4.in_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        mode4 = 1'b0; sel4 = 2'd2; bus4.out_ready = 1'b1;
        bus4.in_valid = 4'b0100;
        bus4.in_data = {$urandom(), $urandom()};
        bus4.in_data[47:32] = 16'd231;
        prep();
        checks++;
        if (bus4.in_ready !== 4'b0100) begin
            failures++; $display("FAIL fixed_ready got=%b exp=0100", bus4.in_ready);
        end
        adv();
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'd231 || bus4.out_src !== 2'd2) begin
            failures++;
            $display("FAIL fixed_load got v=%b src=%0d data=%0d exp v=1 src=2 data=231",
                     bus4.out_valid, bus4.out_src, bus4.out_data);
        end
        bus4.in_valid = '0;
        prep(); adv();
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            failures++; $display("FAIL fixed_drain got v=%b exp v=0", bus4.out_valid);
        end
        for (int c = 0; c < 40; c++) begin
            sel4 = 2'($urandom); bus4.in_valid = 4'($urandom);
            bus4.in_data = {$urandom(), $urandom()}; bus4.out_ready = 1'($urandom);
            prep();
            checks++;
            if (bus4.in_ready !== e_ready) begin
                failures++; $display("FAIL fixed_rand_ready c=%0d got=%b exp=%b", c, bus4.in_ready, e_ready);
            end
            adv();
            checks++;
            if ({bus4.out_valid, bus4.out_src, bus4.out_data} !== {m_valid, m_src, m_data}) begin
                failures++;
                $display("FAIL fixed_rand_out c=%0d got v=%b src=%0d data=%h exp v=%b src=%0d data=%h",
                         c, bus4.out_valid, bus4.out_src, bus4.out_data, m_valid, m_src, m_data);
            end
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; prep(); adv(); rst = 1'b0;
        mode4 = 1'b1; bus4.out_ready = 1'b1; bus4.in_valid = 4'hF;
        bus4.in_data = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        for (int c = 0; c < 8; c++) begin
            prep();
            checks++;
            if (bus4.in_ready !== e_ready) begin
                failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus4.in_ready, e_ready);
            end
            adv();
            checks++;
            if (bus4.out_valid !== 1'b1 || int'(bus4.out_src) != c % 4 ||
                bus4.out_data !== 16'(16'hA0 + c % 4)) begin
                failures++;
                $display("FAIL rr_seq c=%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                         c, bus4.out_valid, bus4.out_src, bus4.out_data, c % 4, 16'hA0 + c % 4);
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [3:0] vals [4] = '{4'b0100, 4'b0011, 4'b0011, 4'b1111};
        int         srcs [4] = '{2, 0, 1, 2};
        mode4 = 1'b1; bus4.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus4.in_valid = vals[c];
            prep(); adv();
            checks++;
            if (bus4.out_valid !== 1'b1 || int'(bus4.out_src) != srcs[c] || m_src !== bus4.out_src) begin
                failures++;
                $display("FAIL skip_wrap c=%0d got v=%b src=%0d exp v=1 src=%0d",
                         c, bus4.out_valid, bus4.out_src, srcs[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode4 = 1'b0; sel4 = 2'd0; bus4.out_ready = 1'b1; bus4.in_valid = 4'b0001;
        bus4.in_data = {$urandom(), $urandom()};
        bus4.in_data[15:0] = 16'h1234;
        prep(); adv();
        bus4.out_ready = 1'b0; bus4.in_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            bus4.in_data = {$urandom(), $urandom()};
            prep();
            checks++;
            if (bus4.in_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, bus4.in_ready);
            end
            adv();
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h1234 || bus4.out_src !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold c=%0d got v=%b src=%0d data=%h exp v=1 src=0 data=1234",
                         c, bus4.out_valid, bus4.out_src, bus4.out_data);
            end
        end
        bus4.out_ready = 1'b1;
        bus4.in_data[15:0] = 16'h5678;
        prep();
        checks++;
        if (bus4.in_ready !== 4'b0001) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=0001", bus4.in_ready);
        end
        adv();
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h5678) begin
            failures++;
            $display("FAIL bp_no_bubble got v=%b data=%h exp v=1 data=5678", bus4.out_valid, bus4.out_data);
        end
        bus4.in_valid = '0;
    endtask

    task automatic test_bad_sel();
        mode3 = 1'b0; sel3 = 2'd3; bus3.in_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            bus3.in_data = 48'({$urandom(), $urandom()}); bus3.out_ready = 1'($urandom);
            prep();
            checks++;
            if (bus3.in_ready !== 3'b000) begin
                failures++; $display("FAIL badsel_ready c=%0d got=%b exp=000", c, bus3.in_ready);
            end
            adv();
            checks++;
            if (bus3.out_valid !== 1'b0) begin
                failures++; $display("FAIL badsel_valid c=%0d got v=%b exp v=0", c, bus3.out_valid);
            end
        end
        sel3 = 2'd2; bus3.out_ready = 1'b1;
        bus3.in_data[47:32] = 16'hBEEF;
        prep(); adv();
        checks++;
        if (bus3.out_valid !== 1'b1 || bus3.out_data !== 16'hBEEF || bus3.out_src !== 2'd2) begin
            failures++;
            $display("FAIL badsel_recover got v=%b src=%0d data=%h exp v=1 src=2 data=beef",
                     bus3.out_valid, bus3.out_src, bus3.out_data);
        end
        bus3.in_valid = '0;
    endtask

    task automatic test_legacy();
        mode2 = 1'b0; bus2.in_valid = 2'b11; bus2.out_ready = 1'b1;
        bus2.in_data = {16'd1, 16'd10};
        for (int c = 0; c < 4; c++) begin
            sel2 = 1'(c % 2);
            prep(); adv();
            checks++;
            if (bus2.out_valid !== 1'b1 || bus2.out_data !== ((c % 2 == 1) ? 16'd1 : 16'd10)) begin
                failures++;
                $display("FAIL legacy c=%0d got v=%b data=%0d exp v=1 data=%0d",
                         c, bus2.out_valid, bus2.out_data, (c % 2 == 1) ? 1 : 10);
            end
        end
        bus2.in_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            mode4 = 1'($urandom); sel4 = 2'($urandom); bus4.in_valid = 4'($urandom);
            bus4.in_data = {$urandom(), $urandom()}; bus4.out_ready = ($urandom_range(0, 9) < 7);
            prep();
            checks++;
            if (bus4.in_ready !== e_ready) begin
                failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus4.in_ready, e_ready);
            end
            adv();
            checks++;
            if ({bus4.out_valid, bus4.out_src, bus4.out_data} !== {m_valid, m_src, m_data}) begin
                failures++;
                $display("FAIL rand_out c=%0d got v=%b src=%0d data=%h exp v=%b src=%0d data=%h",
                         c, bus4.out_valid, bus4.out_src, bus4.out_data, m_valid, m_src, m_data);
            end
`ifdef MULT_N_1_ARB_CNT_EN
            checks++;
            if (cnt4 !== 16'(m_cnt)) begin
                failures++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, cnt4, m_cnt);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; prep(); adv(); rst = 1'b0;
        mode4 = 1'b0; sel4 = 2'd1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus4.in_data = {$urandom(), $urandom()};
            prep(); adv();
        end
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== m_data) begin
            failures++;
            $display("FAIL mid_pre got v=%b data=%h exp v=1 data=%h", bus4.out_valid, bus4.out_data, m_data);
        end
`ifdef MULT_N_1_ARB_CNT_EN
        checks++;
        if (cnt4 !== 16'd3) begin
            failures++; $display("FAIL mid_cnt_pre got=%0d exp=3", cnt4);
        end
`endif
        rst = 1'b1;
        prep();
        checks++;
        if (bus4.in_ready !== 4'b0000) begin
            failures++; $display("FAIL mid_rst_ready got=%b exp=0000", bus4.in_ready);
        end
        adv();
        rst = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 16'd0 || bus4.out_src !== 2'd0) begin
            failures++;
            $display("FAIL mid_post got v=%b src=%0d data=%h exp all zero",
                     bus4.out_valid, bus4.out_src, bus4.out_data);
        end
`ifdef MULT_N_1_ARB_CNT_EN
        checks++;
        if (cnt4 !== 16'd0) begin
            failures++; $display("FAIL mid_cnt_post got=%0d exp=0", cnt4);
        end
`endif
        mode4 = 1'b1; bus4.in_valid = 4'b0110;
        prep();
        checks++;
        if (bus4.in_ready !== 4'b0010) begin
            failures++; $display("FAIL mid_first_grant got=%b exp=0010", bus4.in_ready);
        end
        adv();
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_src !== 2'd1) begin
            failures++;
            $display("FAIL mid_first_src got v=%b src=%0d exp v=1 src=1", bus4.out_valid, bus4.out_src);
        end
    endtask

    initial begin
        rst = 1'b1;
        mode4 = 1'b0; sel4 = '0; mode2 = 1'b0; sel2 = '0; mode3 = 1'b0; sel3 = '0;
        bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0;
        bus2.in_data = '0; bus2.in_valid = '0; bus2.out_ready = 1'b0;
        bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_bad_sel();
        test_legacy();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
